// File: rtl/alu_driver.sv
// -----------------------------------------------------------------------------
// alu_driver
//   Drives one command at a time into an external combinational ALU. It waits
//   a configurable number of settle cycles, captures the ALU result and
//   presents it on a valid/ready result port. Illegal selector/family pairs
//   skip the ALU and return an error result one edge after accept.
//
// Parameters
//   N       operand width
//   SETTLE  ALU settle cycles before sampling (1..7)
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op, cmd_sel            ALU family and selector
//   cmd_a, cmd_b               operands (cmd_b doubles as shift count)
//   cmd_exp                    expected ALU result for self-checking
//   alu_a/alu_b/alu_sel/alu_op registered operands to the ALU
//   alu_out                    combinational ALU result
//   res_valid/res_ready        result handshake
//   res_data, res_match        captured result, comparison against cmd_exp
//   res_err                    command was illegal
//   pass_cnt, fail_cnt         saturating match/mismatch counters
//
// Configuration
//   ALU_DRIVER_SELFCHECK_EN    when defined, builds the cmd_exp comparison,
//                              res_match and both counters; otherwise those
//                              outputs are tied to 0 and cmd_exp is ignored.
// -----------------------------------------------------------------------------
module alu_driver #(
  parameter int N      = 4,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic [2:0]   cmd_sel,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic [N:0]   cmd_exp,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_sel,
  output logic         alu_op,
  input  logic [N:0]   alu_out,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N:0]   res_data,
  output logic         res_match,
  output logic         res_err,
  output logic [7:0]   pass_cnt,
  output logic [7:0]   fail_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, CAPTURE, HOLD} state_e;

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

  state_e       state_q;
  logic [2:0]   settle_q;
  logic [N-1:0] alu_a_q;
  logic [N-1:0] alu_b_q;
  logic [2:0]   alu_sel_q;
  logic         alu_op_q;
  logic [N:0]   res_data_q;
  logic         res_err_q;
  logic         res_valid_q;

  logic         accept;
  logic         cmd_legal;

  // Ready is gated by rst so no command can be taken on a reset edge.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  // Arithmetic family has selectors 0..4, logic family has 0..5.
  assign cmd_legal = cmd_op ? (cmd_sel <= 3'd4) : (cmd_sel <= 3'd5);

`ifdef ALU_DRIVER_SELFCHECK_EN
  logic [N:0] exp_q;
  logic       res_match_q;
  logic [7:0] pass_q;
  logic [7:0] fail_q;
  logic       match_d;

  assign match_d = (alu_out == exp_q);
`else
  // cmd_exp has no consumer in this build.
  logic unused_exp;
  assign unused_exp = ^cmd_exp;
`endif

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge value of the others, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      alu_op_q    <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef ALU_DRIVER_SELFCHECK_EN
      exp_q       <= '0;
      res_match_q <= 1'b0;
      pass_q      <= '0;
      fail_q      <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (cmd_legal) begin
              alu_a_q   <= cmd_a;
              alu_b_q   <= cmd_b;
              alu_sel_q <= cmd_sel;
              alu_op_q  <= cmd_op;
              settle_q  <= '0;
`ifdef ALU_DRIVER_SELFCHECK_EN
              exp_q     <= cmd_exp;
`endif
              state_q   <= DRIVE;
            end else begin
              // Illegal: ALU operands stay untouched, error result at once.
              res_data_q  <= '0;
              res_err_q   <= 1'b1;
              res_valid_q <= 1'b1;
`ifdef ALU_DRIVER_SELFCHECK_EN
              res_match_q <= 1'b0;
`endif
              state_q     <= HOLD;
            end
          end
        end
        DRIVE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= CAPTURE;
          end else begin
            settle_q <= settle_q + 3'd1;
          end
        end
        CAPTURE: begin
          res_data_q  <= alu_out;
          res_err_q   <= 1'b0;
          res_valid_q <= 1'b1;
`ifdef ALU_DRIVER_SELFCHECK_EN
          res_match_q <= match_d;
          if (match_d) begin
            if (pass_q != 8'hFF) pass_q <= pass_q + 8'd1;
          end else begin
            if (fail_q != 8'hFF) fail_q <= fail_q + 8'd1;
          end
`endif
          state_q     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign alu_op    = alu_op_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

`ifdef ALU_DRIVER_SELFCHECK_EN
  assign res_match = res_match_q;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
`else
  assign res_match = 1'b0;
  assign pass_cnt  = 8'd0;
  assign fail_cnt  = 8'd0;
`endif

endmodule
